mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/axi_read_if.sv | 24 ++
 rtl/mem_arb_picker.sv | 30 +++
 rtl/mem_read_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, widths and requester codes for the three-way memory read arbiter.
package mem_arb_pkg;

    localparam int ADDR_W           = 32;
    localparam int LEN_W            = 8;
    localparam int ID_W             = 2;
    localparam int DATA_W           = 64;
    localparam int MAX_BEATS_DEF    = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [ID_W-1:0] REQ_DC = 2'd0;
    localparam logic [ID_W-1:0] REQ_IC = 2'd1;
    localparam logic [ID_W-1:0] REQ_PF = 2'd2;

    // Beat count used for burst tracking; the forwarded ARLEN is never altered.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/axi_read_if.sv
// Simplified AXI read-address and read-data channel bundles (ARLEN is a beat count).
interface axi_read_address;
    import mem_arb_pkg::*;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [ID_W-1:0]   arid;

    modport master (output arvalid, output araddr, output arlen, output arid, input arready);
    modport slave  (input arvalid, input araddr, input arlen, input arid, output arready);
endinterface

interface axi_read_data;
    import mem_arb_pkg::*;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;

    modport master (input rvalid, input rdata, output rready);
    modport slave  (output rvalid, output rdata, input rready);
endinterface

// File: rtl/mem_arb_picker.sv
// Combinational winner selection: fixed priority dc > ic > pf, unless pf is promoted.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic            dc_req,
    input  logic            ic_req,
    input  logic            pf_req,
    input  logic            pf_promote,
    output logic            any_req,
    output logic [ID_W-1:0] winner
);

    // Priority encoder with starvation override for the prefetcher.
    always_comb begin
        any_req = dc_req | ic_req | pf_req;
        winner  = REQ_DC;
        if (pf_req && pf_promote) begin
            winner = REQ_PF;
        end else if (dc_req) begin
            winner = REQ_DC;
        end else if (ic_req) begin
            winner = REQ_IC;
        end else if (pf_req) begin
            winner = REQ_PF;
        end else begin
            winner = REQ_DC;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates D-cache, I-cache and prefetch read bursts onto one memory read port,
// one transaction outstanding at a time.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int MAX_BEATS    = MAX_BEATS_DEF
)
(
    input  logic           clk,
    input  logic           rst_n,
    axi_read_address.slave dc_ra,
    axi_read_data.slave    dc_rd,
    axi_read_address.slave ic_ra,
    axi_read_data.slave    ic_rd,
    axi_read_address.slave pf_ra,
    axi_read_data.slave    pf_rd,
    axi_read_address.master mem_ra,
    axi_read_data.master   mem_rd
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);
    localparam logic [STV_W-1:0] STV_ZERO = STV_W'(0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BEATS);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

    arb_state_e        state_r,    state_nxt_s;
    logic [ID_W-1:0]   grant_r,    grant_nxt_s;
    logic [ADDR_W-1:0] araddr_r,   araddr_nxt_s;
    logic [LEN_W-1:0]  arlen_r,    arlen_nxt_s;
    logic [LEN_W-1:0]  beat_lim_r, beat_lim_nxt_s;
    logic [LEN_W-1:0]  beat_cnt_r, beat_cnt_nxt_s;
    logic [STV_W-1:0]  starve_r,   starve_nxt_s;

    logic              any_req_s;
    logic [ID_W-1:0]   winner_s;
    logic              pf_promote_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [LEN_W-1:0]  sel_len_s;
    logic              in_addr_s;
    logic              in_data_s;
    logic              ar_hs_s;
    logic              rd_hs_s;
    logic              gnt_rready_s;
    logic              unused_arid_s;

    // Requester ARIDs are replaced by the requester code on the memory side.
    assign unused_arid_s = ^{dc_ra.arid, ic_ra.arid, pf_ra.arid};

    assign pf_promote_s = (starve_r == STV_MAX);

    mem_arb_picker u_picker (
        .dc_req     (dc_ra.arvalid),
        .ic_req     (ic_ra.arvalid),
        .pf_req     (pf_ra.arvalid),
        .pf_promote (pf_promote_s),
        .any_req    (any_req_s),
        .winner     (winner_s)
    );

    // Address and length of the arbitration winner, captured on grant.
    always_comb begin
        sel_addr_s = dc_ra.araddr;
        sel_len_s  = dc_ra.arlen;
        case (winner_s)
            REQ_DC: begin
                sel_addr_s = dc_ra.araddr;
                sel_len_s  = dc_ra.arlen;
            end
            REQ_IC: begin
                sel_addr_s = ic_ra.araddr;
                sel_len_s  = ic_ra.arlen;
            end
            REQ_PF: begin
                sel_addr_s = pf_ra.araddr;
                sel_len_s  = pf_ra.arlen;
            end
            default: begin
                sel_addr_s = dc_ra.araddr;
                sel_len_s  = dc_ra.arlen;
            end
        endcase
    end

    // Read-ready of whichever requester currently owns the data channel.
    always_comb begin
        gnt_rready_s = 1'b0;
        case (grant_r)
            REQ_DC:  gnt_rready_s = dc_rd.rready;
            REQ_IC:  gnt_rready_s = ic_rd.rready;
            REQ_PF:  gnt_rready_s = pf_rd.rready;
            default: gnt_rready_s = 1'b0;
        endcase
    end

    // Outputs are gated by rst_n so nothing leaks while reset is held.
    // A zero-length burst never opens the data channel.
    assign in_addr_s = rst_n & (state_r == ST_ADDR);
    assign in_data_s = rst_n & (state_r == ST_DATA) & (beat_lim_r != LEN_ZERO);
    assign ar_hs_s   = in_addr_s & mem_ra.arready;
    assign rd_hs_s   = mem_rd.rvalid & mem_rd.rready;

    assign mem_ra.arvalid = in_addr_s;
    assign mem_ra.araddr  = araddr_r;
    assign mem_ra.arlen   = arlen_r;
    assign mem_ra.arid    = grant_r;

    assign dc_ra.arready = ar_hs_s & (grant_r == REQ_DC);
    assign ic_ra.arready = ar_hs_s & (grant_r == REQ_IC);
    assign pf_ra.arready = ar_hs_s & (grant_r == REQ_PF);

    assign mem_rd.rready = in_data_s & gnt_rready_s;

    assign dc_rd.rvalid = in_data_s & mem_rd.rvalid & (grant_r == REQ_DC);
    assign ic_rd.rvalid = in_data_s & mem_rd.rvalid & (grant_r == REQ_IC);
    assign pf_rd.rvalid = in_data_s & mem_rd.rvalid & (grant_r == REQ_PF);

    assign dc_rd.rdata = mem_rd.rdata;
    assign ic_rd.rdata = mem_rd.rdata;
    assign pf_rd.rdata = mem_rd.rdata;

    // Next-state logic: arbitration in IDLE, address handshake, beat counting.
    always_comb begin
        state_nxt_s    = state_r;
        grant_nxt_s    = grant_r;
        araddr_nxt_s   = araddr_r;
        arlen_nxt_s    = arlen_r;
        beat_lim_nxt_s = beat_lim_r;
        beat_cnt_nxt_s = beat_cnt_r;
        starve_nxt_s   = starve_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s    = ST_ADDR;
                    grant_nxt_s    = winner_s;
                    araddr_nxt_s   = sel_addr_s;
                    arlen_nxt_s    = sel_len_s;
                    beat_lim_nxt_s = clamp_len(sel_len_s, LEN_MAX);
                    beat_cnt_nxt_s = LEN_ZERO;
                    if (winner_s == REQ_PF) begin
                        starve_nxt_s = STV_ZERO;
                    end else if (pf_ra.arvalid && (starve_r != STV_MAX)) begin
                        starve_nxt_s = starve_r + STV_ONE;
                    end else begin
                        starve_nxt_s = starve_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (mem_ra.arready) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (beat_lim_r == LEN_ZERO) begin
                    state_nxt_s = ST_IDLE;
                end else if (rd_hs_s) begin
                    beat_cnt_nxt_s = beat_cnt_r + LEN_ONE;
                    if ((beat_cnt_r + LEN_ONE) == beat_lim_r) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            grant_r    <= REQ_DC;
            araddr_r   <= {ADDR_W{1'b0}};
            arlen_r    <= LEN_ZERO;
            beat_lim_r <= LEN_ZERO;
            beat_cnt_r <= LEN_ZERO;
            starve_r   <= STV_ZERO;
        end else begin
            state_r    <= state_nxt_s;
            grant_r    <= grant_nxt_s;
            araddr_r   <= araddr_nxt_s;
            arlen_r    <= arlen_nxt_s;
            beat_lim_r <= beat_lim_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            starve_r   <= starve_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: directed requests, a scripted memory,
// and a negedge monitor that pops expected address and data transfers.
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_read_address dc_ra();
    axi_read_address ic_ra();
    axi_read_address pf_ra();
    axi_read_address mem_ra();
    axi_read_data    dc_rd();
    axi_read_data    ic_rd();
    axi_read_data    pf_rd();
    axi_read_data    mem_rd();

    mem_read_arbiter #(.STARVE_LIMIT(4), .MAX_BEATS(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dc_ra  (dc_ra),
        .dc_rd  (dc_rd),
        .ic_ra  (ic_ra),
        .ic_rd  (ic_rd),
        .pf_ra  (pf_ra),
        .pf_rd  (pf_rd),
        .mem_ra (mem_ra),
        .mem_rd (mem_rd)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  id;
    } ar_exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
    } beat_exp_t;

    ar_exp_t   exp_ar[$];
    beat_exp_t exp_beat[$];
    int        n_checks = 0;
    int        n_errors = 0;
    int        ar_pulses[3];
    logic      keep[3];
    int        wcyc;
    int        stv_ids[6] = '{0, 0, 0, 0, 2, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name, input int got);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d, expected nothing (t=%0t)", name, got, $time);
    endtask

    function automatic logic req_rvalid(input logic [1:0] id);
        case (id)
            2'd0:    return dc_rd.rvalid;
            2'd1:    return ic_rd.rvalid;
            default: return pf_rd.rvalid;
        endcase
    endfunction

    task automatic set_rready(input logic [1:0] id, input logic v);
        case (id)
            2'd0:    dc_rd.rready = v;
            2'd1:    ic_rd.rready = v;
            default: pf_rd.rready = v;
        endcase
    endtask

    task automatic drop_arvalid(input logic [1:0] id);
        case (id)
            2'd0:    dc_ra.arvalid = 1'b0;
            2'd1:    ic_ra.arvalid = 1'b0;
            default: pf_ra.arvalid = 1'b0;
        endcase
    endtask

    task automatic request(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len);
        case (id)
            2'd0: begin dc_ra.arvalid = 1'b1; dc_ra.araddr = addr; dc_ra.arlen = len; dc_ra.arid = id; end
            2'd1: begin ic_ra.arvalid = 1'b1; ic_ra.araddr = addr; ic_ra.arlen = len; ic_ra.arid = id; end
            default: begin pf_ra.arvalid = 1'b1; pf_ra.araddr = addr; pf_ra.arlen = len; pf_ra.arid = id; end
        endcase
    endtask

    task automatic expect_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] id);
        ar_exp_t e;
        e.addr = addr;
        e.len  = len;
        e.id   = id;
        exp_ar.push_back(e);
    endtask

    task automatic expect_beats(input logic [1:0] id, input logic [63:0] base, input int n);
        beat_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.id   = id;
            e.data = base + 64'(i);
            exp_beat.push_back(e);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_mem_arvalid"}, mem_ra.arvalid, 1'b0);
        check({name, "_mem_rready"}, mem_rd.rready, 1'b0);
        check({name, "_arready"}, {pf_ra.arready, ic_ra.arready, dc_ra.arready}, 3'b000);
        check({name, "_rvalid"}, {pf_rd.rvalid, ic_rd.rvalid, dc_rd.rvalid}, 3'b000);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_idle_arvalid"}, mem_ra.arvalid, 1'b0);
        check({name, "_idle_rready"}, mem_rd.rready, 1'b0);
    endtask

    // Scripted memory: waits for ARVALID, answers after ar_delay cycles, then streams beats.
    task automatic mem_serve(input int ar_delay, input int nbeats, input logic [63:0] base,
                             input int stall_at, input int stall_len, output int wait_cyc);
        int t;
        logic [1:0] gid;
        t = 0;
        while (mem_ra.arvalid !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        wait_cyc = t;
        if (mem_ra.arvalid !== 1'b1) begin
            fail_msg("ar_timeout", t);
            return;
        end
        repeat (ar_delay) begin @(posedge clk); #1; end
        gid = mem_ra.arid;
        mem_ra.arready = 1'b1;
        @(posedge clk); #1;
        mem_ra.arready = 1'b0;
        if (!keep[gid]) drop_arvalid(gid);
        if (nbeats == 0) begin
            mem_rd.rvalid = 1'b1;
            mem_rd.rdata  = base;
            repeat (2) begin
                @(negedge clk);
                check("len0_mem_rready", mem_rd.rready, 1'b0);
                check("len0_rvalid", req_rvalid(gid), 1'b0);
                @(posedge clk); #1;
            end
            mem_rd.rvalid = 1'b0;
        end
        for (int b = 0; b < nbeats; b++) begin
            mem_rd.rvalid = 1'b1;
            mem_rd.rdata  = base + 64'(b);
            if (b == stall_at) begin
                set_rready(gid, 1'b0);
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_mem_rready", mem_rd.rready, 1'b0);
                    check("stall_rvalid", req_rvalid(gid), 1'b1);
                    @(posedge clk); #1;
                end
                set_rready(gid, 1'b1);
            end
            t = 0;
            @(negedge clk);
            while (mem_rd.rready !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (mem_rd.rready !== 1'b1) begin
                fail_msg("beat_timeout", b);
                mem_rd.rvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        mem_rd.rvalid = 1'b0;
    endtask

    ar_exp_t   mon_ea;
    beat_exp_t mon_eb;
    logic [2:0] mon_rdy;

    task automatic mon_beat(input logic [1:0] id, input logic rv, input logic rr);
        if (rv && !mem_rd.rvalid) fail_msg("rvalid_without_mem", int'(id));
        if (rv && rr) begin
            if (exp_beat.size() == 0) begin
                fail_msg("beat_unexpected", int'(id));
            end else begin
                mon_eb = exp_beat.pop_front();
                check("beat_req", id, mon_eb.id);
                check("beat_data", mem_rd.rdata, mon_eb.data);
                check("beat_mem_rready", mem_rd.rready, 1'b1);
            end
        end
    endtask

    // Monitor: compares every address handshake and delivered beat against the scoreboard.
    always @(negedge clk) begin
        mon_rdy = {pf_ra.arready, ic_ra.arready, dc_ra.arready};
        if (mon_rdy != 3'b000 || (mem_ra.arvalid && mem_ra.arready)) begin
            for (int r = 0; r < 3; r++) if (mon_rdy[r]) ar_pulses[r]++;
            if (exp_ar.size() == 0) begin
                fail_msg("ar_unexpected", int'(mon_rdy));
            end else begin
                mon_ea = exp_ar.pop_front();
                check("ar_addr", mem_ra.araddr, mon_ea.addr);
                check("ar_len", mem_ra.arlen, mon_ea.len);
                check("ar_id", mem_ra.arid, mon_ea.id);
                check("ar_ready_route", mon_rdy, 3'b001 << mon_ea.id);
                check("ar_mem_hs", mem_ra.arvalid & mem_ra.arready, 1'b1);
            end
        end
        mon_beat(2'd0, dc_rd.rvalid, dc_rd.rready);
        mon_beat(2'd1, ic_rd.rvalid, ic_rd.rready);
        mon_beat(2'd2, pf_rd.rvalid, pf_rd.rready);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int r = 0; r < 3; r++) begin keep[r] = 1'b0; ar_pulses[r] = 0; end
        dc_ra.arvalid = 1'b0; dc_ra.araddr = 32'h0; dc_ra.arlen = 8'd0; dc_ra.arid = 2'd0;
        ic_ra.arvalid = 1'b0; ic_ra.araddr = 32'h0; ic_ra.arlen = 8'd0; ic_ra.arid = 2'd1;
        pf_ra.arvalid = 1'b0; pf_ra.araddr = 32'h0; pf_ra.arlen = 8'd0; pf_ra.arid = 2'd2;
        dc_rd.rready = 1'b1; ic_rd.rready = 1'b1; pf_rd.rready = 1'b1;
        mem_ra.arready = 1'b0;
        mem_rd.rvalid = 1'b1;
        mem_rd.rdata  = 64'hDEAD;

        // Reset with a stray memory RVALID present.
        repeat (2) begin @(negedge clk); check_quiet("reset"); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); check_quiet("post_reset");
        @(posedge clk); #1;
        mem_rd.rvalid = 1'b0;

        // Single I-cache burst of 4, memory ARREADY after 2 cycles.
        ar_pulses[1] = 0;
        expect_ar(32'h0000100, 8'd4, 2'd1);
        expect_beats(2'd1, 64'h1000, 4);
        request(2'd1, 32'h0000100, 8'd4);
        mem_serve(2, 4, 64'h1000, -1, 0, wcyc);
        check_idle("ic_single");
        check("ic_arready_pulses", ar_pulses[1], 1);

        // D-cache and I-cache together: dc first, ic in the idle cycle after.
        expect_ar(32'h200, 8'd2, 2'd0);
        expect_beats(2'd0, 64'h2000, 2);
        expect_ar(32'h300, 8'd3, 2'd1);
        expect_beats(2'd1, 64'h3000, 3);
        request(2'd0, 32'h200, 8'd2);
        request(2'd1, 32'h300, 8'd3);
        mem_serve(0, 2, 64'h2000, -1, 0, wcyc);
        @(negedge clk);
        check("gap_arvalid", mem_ra.arvalid, 1'b0);
        mem_serve(0, 3, 64'h3000, -1, 0, wcyc);
        check("ic_grant_latency", wcyc, 1);
        check_idle("dc_ic");

        // I-cache RREADY low for 3 cycles on beat 2.
        expect_ar(32'h400, 8'd4, 2'd1);
        expect_beats(2'd1, 64'h4000, 4);
        request(2'd1, 32'h400, 8'd4);
        mem_serve(1, 4, 64'h4000, 2, 3, wcyc);
        check_idle("stall");

        // Zero-length D-cache request.
        ar_pulses[0] = 0;
        expect_ar(32'h500, 8'd0, 2'd0);
        request(2'd0, 32'h500, 8'd0);
        mem_serve(0, 0, 64'h5000, -1, 0, wcyc);
        check_idle("len0");
        check("len0_arready_pulses", ar_pulses[0], 1);

        // Oversized ARLEN forwarded as-is, counted as MAX_BEATS.
        expect_ar(32'h600, 8'd12, 2'd0);
        expect_beats(2'd0, 64'h6000, 8);
        request(2'd0, 32'h600, 8'd12);
        mem_serve(0, 8, 64'h6000, -1, 0, wcyc);
        check_idle("clamp");

        // Reset during beat 2 of 4, then stray memory RVALID.
        expect_ar(32'h700, 8'd4, 2'd1);
        expect_beats(2'd1, 64'h7000, 1);
        request(2'd1, 32'h700, 8'd4);
        mem_serve(1, 1, 64'h7000, -1, 0, wcyc);
        mem_rd.rvalid = 1'b1;
        mem_rd.rdata  = 64'h7001;
        rst_n = 1'b0;
        repeat (2) begin @(negedge clk); check_quiet("mid_reset"); @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); check_quiet("stray_rvalid"); @(posedge clk); #1; end
        mem_rd.rvalid = 1'b0;
        expect_ar(32'h710, 8'd2, 2'd1);
        expect_beats(2'd1, 64'h7100, 2);
        request(2'd1, 32'h710, 8'd2);
        mem_serve(0, 2, 64'h7100, -1, 0, wcyc);
        check_idle("after_reset");

        // Prefetch starvation: dc wins 4 times, pf promoted on the 5th, dc next.
        keep[0] = 1'b1;
        request(2'd0, 32'h800, 8'd1);
        request(2'd2, 32'h900, 8'd1);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) keep[0] = 1'b0;
            if (stv_ids[k] == 2) expect_ar(32'h900, 8'd1, 2'd2);
            else                 expect_ar(32'h800, 8'd1, 2'd0);
            expect_beats(2'(stv_ids[k]), 64'h8000 + 64'(k), 1);
            mem_serve(0, 1, 64'h8000 + 64'(k), -1, 0, wcyc);
        end
        check_idle("starve");

        repeat (2) @(negedge clk);
        check("exp_ar_empty", exp_ar.size(), 0);
        check("exp_beat_empty", exp_beat.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
